// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose
//   Lets the instruction-fetch requester (port I) and the load/store requester
//   (port D) share one single-ported, variable-latency memory bus. One access
//   is in flight at a time. The command of the granted port is latched into
//   registered mem_* outputs and held until the memory answers with mem_ready.
//   The winner then gets a one-cycle ack together with the returned read data.
//   A watchdog aborts an access that memory never completes. The abort returns
//   an ack with bus_err and zero data.
//
// Sequence per access (three-state FSM):
//   IDLE -> BUSY -> DONE -> IDLE
//   The best case is one access every three cycles.
//
// Parameters
//   ADDR_W   address width, on both requester ports and the memory side
//   DATA_W   data width; byte enables are DATA_W/8 bits
//   TIMEOUT  number of BUSY cycles without mem_ready before an abort;
//            0 disables the watchdog
//
// Ports
//   clock, reset                    rising-edge clock; async active-high reset
//   i_req, i_addr                   fetch request, held until i_ack
//   i_ack, i_rdata                  fetch completion pulse and fetched word
//   d_req, d_we, d_addr,            load/store request, held until d_ack
//   d_wdata, d_be
//   d_ack, d_rdata                  load/store completion pulse and load data
//   mem_req, mem_we, mem_addr,      memory command, held until mem_ready
//   mem_wdata, mem_be
//   mem_rdata, mem_ready            memory response (sampled only in BUSY)
//   bus_err                         pulses together with the ack of an
//                                   aborted access
//
// Configuration macro
//   MEM_ARB_RR_EN  When defined, simultaneous requests go to the port that did
//                  not win last time (round-robin). When undefined, port D
//                  always beats port I, because it holds the older instruction.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  // instruction fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  // load/store port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  // memory side
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic                bus_err
);

  localparam int BE_W = DATA_W / 8;
  // The watchdog holds (BUSY cycles - 1). It must be able to reach TIMEOUT-1.
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  state_t              state_q;
  grant_t              last_grant_q;
  logic [WD_W-1:0]     wdog_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic                i_ack_q;
  logic                d_ack_q;
  logic                bus_err_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  // Arbitration decision. It is only consumed in IDLE.
  grant_t grant_d;
  logic   any_req;
  logic   wd_expire;

  always_comb begin
    any_req = i_req | d_req;
    grant_d = GRANT_I;
    if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
      grant_d = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
`else
      grant_d = GRANT_D;
`endif
    end else if (d_req) begin
      grant_d = GRANT_D;
    end
  end

  // wdog_q == TIMEOUT-1 means the current cycle is the TIMEOUT-th BUSY cycle.
  always_comb begin
    wd_expire = (TIMEOUT != 0) && (wdog_q == WD_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_I;
      wdog_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      bus_err_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          i_ack_q   <= 1'b0;
          d_ack_q   <= 1'b0;
          bus_err_q <= 1'b0;
          if (any_req) begin
            last_grant_q <= grant_d;
            wdog_q       <= '0;
            mem_req_q    <= 1'b1;
            if (grant_d == GRANT_D) begin
              mem_we_q    <= d_we;
              mem_addr_q  <= d_addr;
              mem_wdata_q <= d_wdata;
              // Loads read whole words; byte enables only qualify stores.
              mem_be_q    <= d_we ? d_be : '1;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= i_addr;
              mem_wdata_q <= '0;
              mem_be_q    <= '1;
            end
            state_q <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (mem_ready) begin
            if (last_grant_q == GRANT_D) begin
              d_rdata_q <= mem_rdata;
            end else begin
              i_rdata_q <= mem_rdata;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            i_ack_q   <= (last_grant_q == GRANT_I);
            d_ack_q   <= (last_grant_q == GRANT_D);
            state_q   <= ST_DONE;
          end else if (wd_expire) begin
            // Memory never answered. Release the bus and report the abort
            // with zero data.
            if (last_grant_q == GRANT_D) begin
              d_rdata_q <= '0;
            end else begin
              i_rdata_q <= '0;
            end
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            i_ack_q   <= (last_grant_q == GRANT_I);
            d_ack_q   <= (last_grant_q == GRANT_D);
            bus_err_q <= 1'b1;
            state_q   <= ST_DONE;
          end else if (TIMEOUT != 0) begin
            wdog_q <= wdog_q + 1'b1;
          end
        end

        ST_DONE: begin
          // Requests are not sampled here. The requester advances on the
          // ack edge, so its next request must be seen first in IDLE.
          i_ack_q   <= 1'b0;
          d_ack_q   <= 1'b0;
          bus_err_q <= 1'b0;
          state_q   <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int TMO = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        bus_err;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference contents: every word holds a fixed pattern of its address
  // until it is stored to.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Environment memory, served by the responder.
  logic [31:0] env_mem [logic [31:0]];
  // Reference memory, kept in program order by the D driver.
  logic [31:0] ref_mem [logic [31:0]];

  typedef struct packed { logic [31:0] rdata; logic err; } exp_t;
  exp_t exp_i_q[$];
  exp_t exp_d_q[$];
  bit   grant_log[$];   // 1 = D, 0 = I
  int   last_busy_len = 0;

  // ---------------- memory responder ----------------
  int resp_fixed = 0;   // -1: random latency
  bit resp_never = 0;
  bit noise_en   = 0;

  initial begin : responder
    bit in_flight;
    int cnt;
    logic [31:0] w;
    in_flight = 0;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock); #1;
      if (reset || !mem_req) begin
        in_flight = 0;
        mem_ready = noise_en && ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end else begin
        if (!in_flight) begin
          in_flight = 1;
          cnt = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, 5));
        end
        if (resp_never || cnt != 0) begin
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          if (cnt != 0) cnt--;
        end else begin
          mem_ready = 1'b1;
          if (mem_we) begin
            w = env_mem.exists(mem_addr) ? env_mem[mem_addr] : rom(mem_addr);
            env_mem[mem_addr] = merge(w, mem_wdata, mem_be);
            mem_rdata = ~mem_addr;
          end else begin
            mem_rdata = env_mem.exists(mem_addr) ? env_mem[mem_addr] : rom(mem_addr);
          end
        end
      end
    end
  end

  // ---------------- memory-side monitor with arbitration model ----------------
  logic        s_i_req, s_d_req, s_d_we;
  logic [31:0] s_i_addr, s_d_addr, s_d_wdata;
  logic [3:0]  s_d_be;
  bit          model_last = 0;
  logic        prev_mreq = 0;
  logic [31:0] e_addr, e_wdata;
  logic        e_we;
  logic [3:0]  e_be;
  int          busy_len = 0;

  always @(negedge clock) begin
    bit win;
    if (reset) begin
      model_last = 0;
      prev_mreq  = 0;
    end else begin
      if (mem_req && !prev_mreq) begin
        if (!s_i_req && !s_d_req) begin
          fail("mem_spurious", "mem_req rose with no request pending");
        end else begin
          if (s_i_req && s_d_req) begin
`ifdef MEM_ARB_RR_EN
            win = ~model_last;
`else
            win = 1;
`endif
          end else begin
            win = s_d_req;
          end
          model_last = win;
          grant_log.push_back(win);
          if (win) begin
            e_addr = s_d_addr; e_we = s_d_we; e_wdata = s_d_wdata;
            e_be = s_d_we ? s_d_be : 4'hF;
          end else begin
            e_addr = s_i_addr; e_we = 1'b0; e_wdata = '0; e_be = 4'hF;
          end
          check("mem_cmd", 128'({mem_addr, mem_we, mem_be}), 128'({e_addr, e_we, e_be}));
          if (e_we) check("mem_wdata", 128'(mem_wdata), 128'(e_wdata));
          busy_len = 1;
        end
      end else if (mem_req) begin
        busy_len++;
        check("mem_stable", 128'({mem_addr, mem_we, mem_be}), 128'({e_addr, e_we, e_be}));
        if (e_we) check("mem_wdata_stable", 128'(mem_wdata), 128'(e_wdata));
      end else if (prev_mreq) begin
        last_busy_len = busy_len;
      end
      prev_mreq = mem_req;
    end
    s_i_req = i_req; s_i_addr = i_addr;
    s_d_req = d_req; s_d_we = d_we; s_d_addr = d_addr; s_d_wdata = d_wdata; s_d_be = d_be;
  end

  // ---------------- ack scoreboard monitor ----------------
  logic p_i_ack = 0, p_d_ack = 0, p_mreq = 0, p_mready = 0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (i_ack || d_ack) check("acks_exclusive", 128'(i_ack && d_ack), 128'(0));
      if (p_i_ack) check("i_ack_pulse", 128'(i_ack), 128'(0));
      if (p_d_ack) check("d_ack_pulse", 128'(d_ack), 128'(0));
      if (bus_err) check("bus_err_with_ack", 128'(i_ack || d_ack), 128'(1));
      if (i_ack) begin
        check("i_ack_timing", 128'(p_mreq && (p_mready || bus_err)), 128'(1));
        if (exp_i_q.size() == 0) fail("i_ack_unexpected", "i_ack with nothing outstanding");
        else begin
          e = exp_i_q.pop_front();
          check("i_rdata", 128'(i_rdata), 128'(e.rdata));
          check("i_bus_err", 128'(bus_err), 128'(e.err));
        end
      end
      if (d_ack) begin
        check("d_ack_timing", 128'(p_mreq && (p_mready || bus_err)), 128'(1));
        if (exp_d_q.size() == 0) fail("d_ack_unexpected", "d_ack with nothing outstanding");
        else begin
          e = exp_d_q.pop_front();
          check("d_rdata", 128'(d_rdata), 128'(e.rdata));
          check("d_bus_err", 128'(bus_err), 128'(e.err));
        end
      end
    end
    p_i_ack = i_ack; p_d_ack = d_ack; p_mreq = mem_req; p_mready = mem_ready;
  end

  // ---------------- drivers ----------------
  task automatic wait_ack(input bit is_d);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(is_d ? d_ack : i_ack) && n < 200);
    if (!(is_d ? d_ack : i_ack)) fail(is_d ? "d_ack_wait" : "i_ack_wait", "no ack within 200 cycles");
  endtask

  task automatic issue_i(input logic [31:0] addr);
    exp_t e;
    i_req = 1'b1;
    i_addr = addr;
    e.rdata = rom(addr);
    e.err = 1'b0;
    exp_i_q.push_back(e);
    wait_ack(0);
    @(posedge clock); #1;
    i_req = 1'b0;
  endtask

  task automatic issue_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit abort);
    exp_t e;
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    e.err = abort;
    if (abort) e.rdata = '0;
    else if (we) begin
      e.rdata = ~addr;
      ref_mem[addr] = merge(ref_mem.exists(addr) ? ref_mem[addr] : rom(addr), wdata, be);
    end else e.rdata = ref_mem.exists(addr) ? ref_mem[addr] : rom(addr);
    exp_d_q.push_back(e);
    wait_ack(1);
    @(posedge clock); #1;
    d_req = 1'b0;
  endtask

  task automatic rand_d();
    issue_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
            4'($urandom_range(1, 15)), 0);
  endtask

  function automatic logic [5:0] grants6();
    logic [5:0] v;
    v = '0;
    foreach (grant_log[k]) v = {v[4:0], grant_log[k]};
    return v;
  endfunction

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int gap;
    exp_t e;
    reset = 1'b1;
    i_req = 1'b1; i_addr = 32'h1000_0040;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

    // 1: reset held with a pending fetch, then minimum-latency fetch
    repeat (3) @(negedge clock);
    check("rst_ctrl", 128'({mem_req, mem_we, i_ack, d_ack, bus_err}), 128'(0));
    check("rst_data", 128'({mem_addr, mem_wdata, mem_be, i_rdata, d_rdata}), 128'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    e.rdata = rom(32'h1000_0040); e.err = 1'b0;
    exp_i_q.push_back(e);
    @(negedge clock);
    check("t1_idle_mem_req", 128'(mem_req), 128'(0));
    @(negedge clock);
    check("t1_mem_req_at_1", 128'({mem_req, i_ack}), 128'(2'b10));
    @(negedge clock);
    check("t1_i_ack_at_2", 128'(i_ack), 128'(1));
    @(posedge clock); #1;
    i_req = 1'b0;

    // 2: simultaneous requests, store wins first
    grant_log.delete();
    fork
      issue_d(1'b1, 32'h10, 32'hDEADBEEF, 4'b0011, 0);
      issue_i(32'h1000_0010);
    join
    check("t2_grant_order", 128'({grant_log.size(), grants6()}), 128'({32'd2, 6'b000010}));
    issue_d(1'b0, 32'h10, '0, '0, 0);   // reads back the merged word

    // 3: both held continuously
    @(posedge clock); #1; reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    grant_log.delete();
    fork
      begin for (int k = 0; k < 3; k++) issue_i(32'h1000_0100 + 32'(k * 4)); end
      begin for (int k = 0; k < 3; k++) rand_d(); end
    join
`ifdef MEM_ARB_RR_EN
    check("t3_grant_order", 128'({grant_log.size(), grants6()}), 128'({32'd6, 6'b101010}));
`else
    check("t3_grant_order", 128'({grant_log.size(), grants6()}), 128'({32'd6, 6'b111000}));
`endif

    // 4: slow memory
    resp_fixed = 7;
    issue_d(1'b0, 32'h24, '0, '0, 0);
    check("t4_busy_len", 128'(last_busy_len), 128'(8));
    issue_i(32'h1000_0200);
    check("t4_i_busy_len", 128'(last_busy_len), 128'(8));
    resp_fixed = 0;

    // 5: watchdog abort
    resp_never = 1;
    issue_d(1'b0, 32'h28, '0, '0, 1);
    check("t5_busy_len", 128'(last_busy_len), 128'(TMO));
    resp_never = 0;
    issue_d(1'b0, 32'h28, '0, '0, 0);

    // 6: reset in the middle of an access
    resp_never = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clock); n++; end
    check("t6_busy_reached", 128'(mem_req), 128'(1));
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("t6_reset_abort", 128'({mem_req, i_ack, d_ack, bus_err}), 128'(0));
    d_req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    resp_never = 0;
    issue_d(1'b0, 32'h20, '0, '0, 0);

    // random traffic with random latency and stray mem_ready pulses
    resp_fixed = -1;
    noise_en = 1;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          issue_i(32'h1000_0000 + (32'($urandom_range(0, 63)) << 2));
          gap = int'($urandom_range(0, 3));
          if (gap > 0) begin repeat (gap) @(posedge clock); #1; end
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          rand_d();
          gap = int'($urandom_range(0, 3));
          if (gap > 0) begin repeat (gap) @(posedge clock); #1; end
        end
      end
    join
    noise_en = 0;
    repeat (4) @(negedge clock);
    check("outstanding_i", 128'(exp_i_q.size()), 128'(0));
    check("outstanding_d", 128'(exp_d_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
